// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NUM_REQ requesters,
// with a registered, held response. Define ADDER_ARB_OVERFLOW_EN to add rsp_ovf.
module adder_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id
`ifdef ADDER_ARB_OVERFLOW_EN
    ,
    output logic                     rsp_ovf
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]         r_state;
    logic [ID_W-1:0]    r_last_grant;
    logic [WIDTH-1:0]   r_data;
    logic [ID_W-1:0]    r_id;

    logic               w_accept;
    logic               w_found;
    logic               w_take;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [ID_W-1:0]    w_grant_id;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_sum;

    // A new operand pair can be taken when nothing is held or the held result leaves now.
    assign w_accept = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && rsp_ready);

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_found    = 1'b0;
        w_grant_oh = '0;
        w_grant_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] &&
                    (i == (int'(r_last_grant) + k) % NUM_REQ)) begin
                    w_found       = 1'b1;
                    w_grant_oh[i] = 1'b1;
                    w_grant_id    = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_a = req_a[WIDTH*i +: WIDTH];
                w_b = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Carry-out is dropped: the sum wraps modulo 2^WIDTH.
    assign w_sum  = w_a + w_b;
    assign w_take = w_accept && w_found;

    // Reset gates the grant so no operands are consumed while the block is held in reset.
    assign req_ready = (w_accept && !reset) ? w_grant_oh : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_data       <= '0;
            r_id         <= '0;
        end else if (w_accept) begin
            if (w_found) begin
                r_state      <= ST_HOLD;
                r_data       <= w_sum;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

`ifdef ADDER_ARB_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf;

    // Signed overflow: operands share a sign and the sum's sign differs from it.
    assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_take) begin
            r_ovf <= w_ovf;
        end
    end

    assign rsp_ovf = r_ovf;
`endif

    assign rsp_valid = (r_state == ST_HOLD);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;

endmodule
